cabac_se_arb: RTL and testbench

- Round-robin arbiter and write scheduler for the 8-entry, 76-bit syntax-element buffer in front of CABAC binarization.
- Shares the single buffer write port among N syntax-element producers (e.g. CU header, residual, SAO).
- Locks the grant for a whole burst, so one producer's elements are never interleaved with another's.
- Tracks buffer occupancy with a credit counter, so it never writes into a full buffer and does not depend on the buffer's registered full flag.

---
 rtl/cabac_arb_pkg.sv | 14 +
 rtl/cabac_se_arb_if.sv | 24 ++
 rtl/cabac_rr_pick.sv | 27 ++
 rtl/cabac_se_arb.sv | 83 ++++++++
 tb/tb_cabac_se_arb.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cabac_arb_pkg.sv
// cabac_arb_pkg: shared sizes, FSM encoding and lane-slice helper for the
// syntax-element buffer arbiter.
package cabac_arb_pkg;
   localparam int N = 3;
   localparam int W = 76;
   localparam int DEPTH = 8;
   localparam int CW = 4;
   localparam int IW = 2;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;
   function automatic logic [W-1:0] lane(input logic [N*W-1:0] d, input logic [IW-1:0] i);
      return d[int'(i)*W +: W];
   endfunction
endpackage

// File: rtl/cabac_se_arb_if.sv
// cabac_se_arb_if: producer lanes, buffer write port and status of the
// syntax-element arbiter.
interface cabac_se_arb_if;
   import cabac_arb_pkg::*;
   logic [N-1:0]   req_i;
   logic [N-1:0]   last_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   gnt_o;
   logic           fifo_wr_o;
   logic [W-1:0]   fifo_data_o;
   logic           fifo_rd_i;
   logic [CW-1:0]  credit_o;
   logic           lock_o;
   logic [IW-1:0]  owner_o;
   logic           err_o;
   modport slave (
      input  req_i, last_i, data_i, fifo_rd_i,
      output gnt_o, fifo_wr_o, fifo_data_o, credit_o, lock_o, owner_o, err_o
   );
   modport master (
      output req_i, last_i, data_i, fifo_rd_i,
      input  gnt_o, fifo_wr_o, fifo_data_o, credit_o, lock_o, owner_o, err_o
   );
endinterface

// File: rtl/cabac_rr_pick.sv
// cabac_rr_pick: combinational circular priority pick starting at ptr_i.
module cabac_rr_pick
   import cabac_arb_pkg::*;
(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   // Scan from farthest to nearest so the nearest requester is written last and wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         int c;
         c = (int'(ptr_i) + k) % N;
         if (req_i[c]) begin
            gnt_o    = '0;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
            any_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cabac_se_arb.sv
// cabac_se_arb: burst-locked round-robin arbiter and credit-tracked write
// scheduler for the syntax-element buffer.
module cabac_se_arb
   import cabac_arb_pkg::*;
(
   input logic           clk,
   input logic           rst,
   cabac_se_arb_if.slave bus
);
   logic [0:0]    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, sel, pick_idx;
   logic [CW-1:0] credit_q, credit_d;
   logic [N-1:0]  pick_gnt, own_gnt;
   logic [W-1:0]  data_q;
   logic          wr_q, err_q, err_d, pick_any, lock, acc, rd;

   function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
      return (int'(i) == N - 1) ? '0 : i + 1'b1;
   endfunction

   cabac_rr_pick u_pick (
      .req_i (bus.req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign rd      = bus.fifo_rd_i;
   assign lock    = state_q == LOCK;
   assign own_gnt = N'(1) << owner_q;
   assign sel     = lock ? owner_q : pick_idx;
   // Accept is judged on the pre-update credit, so a same-cycle pop cannot unblock a write.
   assign acc     = (credit_q != '0) && (lock ? bus.req_i[owner_q] : pick_any);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      err_d    = err_q;
      credit_d = credit_q;
      if (acc && bus.last_i[sel]) begin
         state_d = IDLE;
         ptr_d   = inc(sel);
      end else if (acc) begin
         state_d = LOCK;
         owner_d = sel;
      end
      if (acc && !rd) credit_d = credit_q - 1'b1;
      if (!acc && rd) begin
         credit_d = (credit_q == CW'(DEPTH)) ? credit_q : credit_q + 1'b1;
         err_d    = err_q | (credit_q == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= CW'(DEPTH);
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         err_q    <= err_d;
         wr_q     <= acc;
         if (acc) data_q <= lane(bus.data_i, sel);
      end
   end

   assign bus.gnt_o       = acc ? (lock ? own_gnt : pick_gnt) : '0;
   assign bus.fifo_wr_o   = wr_q;
   assign bus.fifo_data_o = data_q;
   assign bus.credit_o    = credit_q;
   assign bus.lock_o      = lock;
   assign bus.owner_o     = owner_q;
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_cabac_se_arb.sv
// tb_cabac_se_arb: directed vector table plus randomized traffic checked
// against a queue-free behavioural model of arbitration and credits.
module tb_cabac_se_arb;
   import cabac_arb_pkg::*;

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  last;
      logic          rd;
      logic [N-1:0]  gnt;
      logic [CW-1:0] credit;
      logic          lock;
      logic          err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   cabac_se_arb_if bus ();

   cabac_se_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int m_credit, m_owner, m_ptr;
   logic m_err;
   logic exp_wr;
   logic [W-1:0] exp_data;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_init();
      m_credit = DEPTH;
      m_owner  = -1;
      m_ptr    = 0;
      m_err    = 1'b0;
      exp_wr   = 1'b0;
      exp_data = '0;
   endtask

   task automatic model(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic rd, output logic [N-1:0] g);
      int s;
      s = -1;
      if (m_credit > 0) begin
         if (m_owner >= 0) begin
            if (rq[m_owner]) s = m_owner;
         end else begin
            for (int k = 0; k < N; k++)
               if (s < 0 && rq[(m_ptr + k) % N]) s = (m_ptr + k) % N;
         end
      end
      g = '0;
      if (s >= 0) begin
         g[s] = 1'b1;
         if (lt[s]) begin
            m_owner = -1;
            m_ptr   = (s + 1) % N;
         end else m_owner = s;
      end
      m_credit = m_credit + (rd ? 1 : 0) - (s >= 0 ? 1 : 0);
      if (m_credit > DEPTH) begin
         m_credit = DEPTH;
         m_err    = 1'b1;
      end
   endtask

   task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic rd,
                       input logic [N-1:0] eg, input logic [CW-1:0] ecr, input logic el,
                       input logic ee, input int eo);
      logic [N*W-1:0] d;
      logic [95:0] r;
      for (int i = 0; i < N; i++) begin
         r = {$urandom, $urandom, $urandom};
         d[i*W +: W] = r[W-1:0];
      end
      bus.req_i     = rq;
      bus.last_i    = lt;
      bus.fifo_rd_i = rd;
      bus.data_i    = d;
      #1;
      chk("gnt", W'(bus.gnt_o), W'(eg));
      exp_wr = |eg;
      for (int i = 0; i < N; i++) if (eg[i]) exp_data = d[i*W +: W];
      @(posedge clk);
      #1;
      chk("fifo_wr", W'(bus.fifo_wr_o), W'(exp_wr));
      chk("fifo_data", bus.fifo_data_o, exp_data);
      chk("credit", W'(bus.credit_o), W'(ecr));
      chk("lock", W'(bus.lock_o), W'(el));
      chk("err", W'(bus.err_o), W'(ee));
      if (eo >= 0) chk("owner", W'(bus.owner_o), W'(eo));
   endtask

   task automatic do_reset(input logic [N-1:0] rq, input logic [N-1:0] lt);
      bus.req_i     = rq;
      bus.last_i    = lt;
      bus.fifo_rd_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_init();
      chk("rst_lock", W'(bus.lock_o), '0);
      chk("rst_credit", W'(bus.credit_o), W'(DEPTH));
      chk("rst_err", W'(bus.err_o), '0);
      chk("rst_wr", W'(bus.fifo_wr_o), '0);
      chk("rst_data", bus.fifo_data_o, '0);
      chk("rst_owner", W'(bus.owner_o), '0);
   endtask

   function automatic vec_t v(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic rd,
                              input logic [N-1:0] g, input int c, input logic l, input logic e);
      vec_t x;
      x.req = rq; x.last = lt; x.rd = rd; x.gnt = g; x.credit = CW'(c); x.lock = l; x.err = e;
      return x;
   endfunction

   initial begin
      logic [N-1:0] g, rq, lt;
      logic rd;
      // reset idle, round robin, burst lock with owner stall, backpressure, simultaneous pop, overflow
      for (int i = 0; i < 3; i++) tbl.push_back(v(3'b000, 3'b000, 1'b0, 3'b000, 8, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b001, 7, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b010, 6, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b100, 5, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b001, 4, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b000, 1'b1, 3'b010, 4, 1'b1, 1'b0));
      tbl.push_back(v(3'b111, 3'b000, 1'b1, 3'b010, 4, 1'b1, 1'b0));
      tbl.push_back(v(3'b101, 3'b000, 1'b0, 3'b000, 4, 1'b1, 1'b0));
      tbl.push_back(v(3'b111, 3'b000, 1'b1, 3'b010, 4, 1'b1, 1'b0));
      tbl.push_back(v(3'b111, 3'b010, 1'b1, 3'b010, 4, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b100, 3, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b001, 2, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b010, 1, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b100, 0, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b000, 0, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b1, 3'b000, 1, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b0, 3'b001, 0, 1'b0, 1'b0));
      tbl.push_back(v(3'b000, 3'b000, 1'b1, 3'b000, 1, 1'b0, 1'b0));
      tbl.push_back(v(3'b111, 3'b111, 1'b1, 3'b010, 1, 1'b0, 1'b0));
      for (int c = 2; c <= DEPTH; c++) tbl.push_back(v(3'b000, 3'b000, 1'b1, 3'b000, c, 1'b0, 1'b0));
      tbl.push_back(v(3'b000, 3'b000, 1'b1, 3'b000, 8, 1'b0, 1'b1));
      tbl.push_back(v(3'b000, 3'b000, 1'b0, 3'b000, 8, 1'b0, 1'b1));

      bus.req_i     = '0;
      bus.last_i    = '0;
      bus.fifo_rd_i = 1'b0;
      bus.data_i    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_init();

      foreach (tbl[i]) begin
         model(tbl[i].req, tbl[i].last, tbl[i].rd, g);
         step(tbl[i].req, tbl[i].last, tbl[i].rd, tbl[i].gnt, tbl[i].credit, tbl[i].lock, tbl[i].err, -1);
      end

      do_reset(3'b000, 3'b000);
      for (int i = 0; i < 600; i++) begin
         rq = N'($urandom);
         for (int k = 0; k < N; k++) lt[k] = ($urandom_range(0, 3) == 0);
         rd = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         model(rq, lt, rd, g);
         step(rq, lt, rd, g, CW'(m_credit), m_owner >= 0, m_err, m_owner);
      end

      // lane0 burst aborted by reset; next arbitration restarts at lane 0
      do_reset(3'b000, 3'b000);
      model(3'b001, 3'b000, 1'b0, g);
      step(3'b001, 3'b000, 1'b0, g, CW'(m_credit), 1'b1, 1'b0, 0);
      model(3'b001, 3'b000, 1'b0, g);
      step(3'b001, 3'b000, 1'b0, g, CW'(m_credit), 1'b1, 1'b0, 0);
      do_reset(3'b001, 3'b000);
      model(3'b111, 3'b111, 1'b0, g);
      step(3'b111, 3'b111, 1'b0, g, CW'(m_credit), 1'b0, 1'b0, -1);
      chk("ptr_after_rst", W'(g), W'(3'b001));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
